// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and helpers for the multi-port memory arbiter.
//   port_id_width(n) : bits needed to name one of n ports (never less than 1)
//   mem_cmd_t        : one RAM command {we, addr, wdata}
//   rd_tag_t         : in-flight read marker {valid, id} carried alongside
//                      the RAM read latency
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int MEM_ADDR_WIDTH = 8;
    localparam int MEM_DATA_WIDTH = 32;

    // Wide enough to tag any of up to 8 requester ports.
    localparam int TAG_ID_WIDTH = 3;

    function automatic int port_id_width(input int n);
        int w;
        w = $clog2(n);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

    typedef struct packed {
        logic                      we;
        logic [MEM_ADDR_WIDTH-1:0] addr;
        logic [MEM_DATA_WIDTH-1:0] wdata;
    } mem_cmd_t;

    typedef struct packed {
        logic                    valid;
        logic [TAG_ID_WIDTH-1:0] id;
    } rd_tag_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the requester-side handshake and the RAM command/data bus.
//   req_valid/req_ready/req_we : per-port request handshake and direction
//   req_addr/req_wdata         : packed per-port address and write data
//   rsp_valid/rsp_rdata        : per-port read strobe, shared read data
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata : single-port RAM bus
// Modports:
//   slave  : the arbiter's view (receives requests, drives the RAM)
//   master : the surrounding system's view (requesters plus the RAM)
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_PORTS  = 2
);

    logic [NUM_PORTS-1:0]            req_valid;
    logic [NUM_PORTS-1:0]            req_ready;
    logic [NUM_PORTS-1:0]            req_we;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata;

    logic [NUM_PORTS-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]           rsp_rdata;

    logic                            mem_en;
    logic                            mem_we;
    logic [ADDR_WIDTH-1:0]           mem_addr;
    logic [DATA_WIDTH-1:0]           mem_wdata;
    logic [DATA_WIDTH-1:0]           mem_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter with a registered priority pointer.
//   clk, rst_n : clock and asynchronous active-low reset
//   req[N]     : request vector
//   advance    : the current grant is being consumed; move the pointer
//   grant[N]   : one-hot grant, combinational from req and the pointer
// The search starts at the pointer and wraps; after a consumed grant to
// port g the pointer moves to g+1 (mod N). Idle cycles leave it alone.
// ---------------------------------------------------------------------------
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int PTR_W = port_id_width(N);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W-1:0] win;
    logic             found;
    int               idx;

    // Scan N positions starting at the pointer; the index wraps by a single
    // subtraction because pointer and offset are both below N.
    always_comb begin
        grant = '0;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx[PTR_W-1:0]]) begin
                grant[idx[PTR_W-1:0]] = 1'b1;
                win                   = idx[PTR_W-1:0];
                found                 = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance && found) begin
            ptr_d = (win == PTR_W'(N - 1)) ? '0 : win + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Round-robin front end that shares one synchronous single-port RAM among
// NUM_PORTS requesters.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : mem_port_arbiter_if.slave
//                  requests in  (req_valid/req_we/req_addr/req_wdata)
//                  grants out   (req_ready, at most one bit set)
//                  responses    (rsp_valid one-hot strobe, rsp_rdata)
//                  RAM command  (mem_en/mem_we/mem_addr/mem_wdata, registered)
//                  RAM data in  (mem_rdata)
// A request accepted in cycle T drives the RAM in T+1; its read data comes
// back to the issuing port in T+1+RD_LATENCY.
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = MEM_DATA_WIDTH,
    parameter int NUM_PORTS  = 2,
    parameter int RD_LATENCY = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.slave  bus
);

    logic [NUM_PORTS-1:0]    grant;
    logic                    advance;

    mem_cmd_t                sel_cmd;
    logic [TAG_ID_WIDTH-1:0] sel_id;

    logic                    mem_en_q;
    logic                    mem_en_d;
    mem_cmd_t                cmd_q;
    mem_cmd_t                cmd_d;
    logic [TAG_ID_WIDTH-1:0] cmd_id_q;
    logic [TAG_ID_WIDTH-1:0] cmd_id_d;

    rd_tag_t [RD_LATENCY-1:0] tag_q;
    rd_tag_t [RD_LATENCY-1:0] tag_d;
    rd_tag_t                  tag_tail;

    rr_arbiter #(
        .N (NUM_PORTS)
    ) u_rr_arbiter (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (bus.req_valid),
        .advance (advance),
        .grant   (grant)
    );

    // Every grant is a completed transfer: there is no stall on the RAM side.
    assign advance       = |grant;
    assign bus.req_ready = grant;

    // Unpack the granted port's request; grant is one-hot so at most one
    // iteration contributes.
    always_comb begin
        sel_cmd = '0;
        sel_id  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (grant[p]) begin
                sel_cmd.we    = bus.req_we[p];
                sel_cmd.addr  = bus.req_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
                sel_cmd.wdata = bus.req_wdata[p*DATA_WIDTH +: DATA_WIDTH];
                sel_id        = TAG_ID_WIDTH'(p);
            end
        end
    end

    // Idle cycles drop enable and write strobe but keep address/data, so the
    // RAM bus does not toggle needlessly.
    always_comb begin
        mem_en_d = advance;
        cmd_d    = cmd_q;
        cmd_d.we = 1'b0;
        cmd_id_d = cmd_id_q;
        if (advance) begin
            cmd_d    = sel_cmd;
            cmd_id_d = sel_id;
        end
    end

    // Read tags enter the pipeline in the same cycle the RAM sees the command
    // and reach the tail exactly when mem_rdata becomes valid.
    always_comb begin
        tag_d          = tag_q;
        tag_d[0].valid = mem_en_q & ~cmd_q.we;
        tag_d[0].id    = cmd_id_q;
        for (int s = 1; s < RD_LATENCY; s++) begin
            tag_d[s] = tag_q[s-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_en_q <= 1'b0;
            cmd_q    <= '0;
            cmd_id_q <= '0;
            tag_q    <= '0;
        end else begin
            mem_en_q <= mem_en_d;
            cmd_q    <= cmd_d;
            cmd_id_q <= cmd_id_d;
            tag_q    <= tag_d;
        end
    end

    assign tag_tail = tag_q[RD_LATENCY-1];

    always_comb begin
        bus.rsp_valid = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            bus.rsp_valid[p] = tag_tail.valid && (tag_tail.id == TAG_ID_WIDTH'(p));
        end
    end

    assign bus.rsp_rdata = bus.mem_rdata;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = cmd_q.we;
    assign bus.mem_addr  = cmd_q.addr;
    assign bus.mem_wdata = cmd_q.wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Drives the arbiter through directed and random request traffic, models the
// RAM behind it, and compares every cycle against a transaction-level model
// (grant search, command expectation, queue of due responses).
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int NP  = 2;
    localparam int AW  = 8;
    localparam int DW  = 32;
    localparam int RDL = 1;

    typedef struct {
        int            due;
        int            port;
        logic [DW-1:0] data;
    } rsp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_PORTS(NP)) bus ();

    mem_port_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_PORTS  (NP),
        .RD_LATENCY (RDL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Initial RAM image, shared by the RAM model and the reference model.
    function automatic logic [DW-1:0] seedWord(input int a);
        if (a == 16) begin
            return 32'hDEAD_BEEF;
        end
        return (32'(a) * 32'h0101_0101) ^ 32'hA5C3_0F1E;
    endfunction

    // Synchronous single-port RAM with one cycle of read latency.
    logic [DW-1:0] ram [256];
    logic [DW-1:0] ram_rdata;
    assign bus.mem_rdata = ram_rdata;

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i] = seedWord(i);
        end
        forever begin
            @(posedge clk);
            if (bus.mem_en) begin
                if (bus.mem_we) begin
                    ram[bus.mem_addr] = bus.mem_wdata;
                end else begin
                    ram_rdata <= ram[bus.mem_addr];
                end
            end
        end
    end

    // Reference model state.
    logic [DW-1:0] m_mem [256];
    int            m_ptr;
    logic          m_en;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    rsp_t          rspq [$];
    int            cycle;

    // Requester state: each port holds its request until it is granted.
    logic [NP-1:0] pend_valid;
    logic [NP-1:0] pend_we;
    logic [AW-1:0] pend_addr  [NP];
    logic [DW-1:0] pend_wdata [NP];
    logic [NP-1:0] obs_ready;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cycle);
        end
    endtask

    task automatic setRequest(input int p, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        pend_valid[p] = 1'b1;
        pend_we[p]    = we;
        pend_addr[p]  = addr;
        pend_wdata[p] = wdata;
    endtask

    // One clock cycle: drive pending requests, compare all outputs with the
    // model, then advance the model by what should have happened.
    task automatic applyStimulus();
        int            g;
        int            cand;
        logic [NP-1:0] exp_grant;
        logic [NP-1:0] exp_rsp;
        logic [DW-1:0] exp_data;
        @(negedge clk);
        bus.req_valid = pend_valid;
        bus.req_we    = pend_we;
        for (int p = 0; p < NP; p++) begin
            bus.req_addr[p*AW +: AW]  = pend_addr[p];
            bus.req_wdata[p*DW +: DW] = pend_wdata[p];
        end
        #1;
        g = -1;
        for (int k = 0; k < NP; k++) begin
            cand = (m_ptr + k) % NP;
            if (g < 0 && pend_valid[cand]) begin
                g = cand;
            end
        end
        exp_grant = '0;
        if (g >= 0) begin
            exp_grant[g] = 1'b1;
        end
        obs_ready = bus.req_ready;
        checkOutput("req_ready", 64'(bus.req_ready), 64'(exp_grant));
        checkOutput("mem_en", 64'(bus.mem_en), 64'(m_en));
        checkOutput("mem_we", 64'(bus.mem_we), 64'(m_we));
        checkOutput("mem_addr", 64'(bus.mem_addr), 64'(m_addr));
        checkOutput("mem_wdata", 64'(bus.mem_wdata), 64'(m_wdata));
        exp_rsp  = '0;
        exp_data = '0;
        if (rspq.size() > 0 && rspq[0].due == cycle) begin
            exp_rsp[rspq[0].port] = 1'b1;
            exp_data              = rspq[0].data;
            void'(rspq.pop_front());
        end
        checkOutput("rsp_valid", 64'(bus.rsp_valid), 64'(exp_rsp));
        if (exp_rsp != '0) begin
            checkOutput("rsp_rdata", 64'(bus.rsp_rdata), 64'(exp_data));
        end
        if (g >= 0) begin
            m_en    = 1'b1;
            m_we    = pend_we[g];
            m_addr  = pend_addr[g];
            m_wdata = pend_wdata[g];
            if (pend_we[g]) begin
                m_mem[pend_addr[g]] = pend_wdata[g];
            end else begin
                rspq.push_back('{due: cycle + 1 + RDL, port: g, data: m_mem[pend_addr[g]]});
            end
            m_ptr         = (g + 1) % NP;
            pend_valid[g] = 1'b0;
        end else begin
            m_en = 1'b0;
            m_we = 1'b0;
        end
        cycle++;
    endtask

    task automatic idleCycles(input int n);
        pend_valid = '0;
        repeat (n) applyStimulus();
    endtask

    task automatic modelReset();
        rspq.delete();
        m_ptr      = 0;
        m_en       = 1'b0;
        m_we       = 1'b0;
        m_addr     = '0;
        m_wdata    = '0;
        pend_valid = '0;
    endtask

    // Asserts reset immediately (mid-cycle), holds it, releases on a negedge.
    task automatic asyncReset(input int n);
        rst_n         = 1'b0;
        bus.req_valid = '0;
        modelReset();
        #1;
        checkOutput("rst_mem_en", 64'(bus.mem_en), 64'(0));
        checkOutput("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            m_mem[i] = seedWord(i);
        end
        cycle     = 0;
        pend_we   = '0;
        for (int p = 0; p < NP; p++) begin
            pend_addr[p]  = '0;
            pend_wdata[p] = '0;
        end
        modelReset();

        // Reset with random inputs: registered outputs must stay cleared.
        repeat (3) begin
            @(negedge clk);
            bus.req_valid = NP'($urandom);
            bus.req_we    = NP'($urandom);
            bus.req_addr  = (NP*AW)'({$urandom, $urandom});
            bus.req_wdata = (NP*DW)'({$urandom, $urandom});
            #1;
            checkOutput("reset_mem_en", 64'(bus.mem_en), 64'(0));
            checkOutput("reset_mem_we", 64'(bus.mem_we), 64'(0));
            checkOutput("reset_mem_addr", 64'(bus.mem_addr), 64'(0));
            checkOutput("reset_mem_wdata", 64'(bus.mem_wdata), 64'(0));
            checkOutput("reset_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        end
        bus.req_valid = '0;
        #1;
        checkOutput("reset_req_ready", 64'(bus.req_ready), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] contention: both ports reading");
        for (int k = 0; k < 4; k++) begin
            for (int p = 0; p < NP; p++) begin
                if (!pend_valid[p]) begin
                    setRequest(p, 1'b0, AW'(8'h20 + 2*k + p), '0);
                end
            end
            applyStimulus();
            checkOutput("contend_grant", 64'(obs_ready), 64'((k % 2 == 0) ? 2'b01 : 2'b10));
        end
        idleCycles(3);

        $display("[TB] single read from port 1");
        setRequest(1, 1'b0, 8'h10, '0);
        applyStimulus();
        applyStimulus();
        checkOutput("single_mem_en", 64'(bus.mem_en), 64'(1));
        checkOutput("single_mem_addr", 64'(bus.mem_addr), 64'(8'h10));
        applyStimulus();
        checkOutput("single_rsp_valid", 64'(bus.rsp_valid), 64'(2'b10));
        checkOutput("single_rsp_rdata", 64'(bus.rsp_rdata), 64'(32'hDEAD_BEEF));
        idleCycles(2);

        $display("[TB] write then read");
        setRequest(0, 1'b1, 8'h03, 32'h55AA_55AA);
        applyStimulus();
        setRequest(0, 1'b0, 8'h03, '0);
        applyStimulus();
        applyStimulus();
        checkOutput("wr_no_rsp", 64'(bus.rsp_valid), 64'(0));
        applyStimulus();
        checkOutput("wr_rd_valid", 64'(bus.rsp_valid), 64'(2'b01));
        checkOutput("wr_rd_data", 64'(bus.rsp_rdata), 64'(32'h55AA_55AA));
        idleCycles(2);

        $display("[TB] streaming on port 0");
        for (int k = 0; k < 8; k++) begin
            setRequest(0, 1'b0, AW'(8'h40 + k), '0);
            applyStimulus();
            checkOutput("stream_ready", 64'(obs_ready[0]), 64'(1));
        end
        idleCycles(3);

        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < NP; p++) begin
                if (!pend_valid[p] && $urandom_range(0, 99) < 60) begin
                    setRequest(p, 1'($urandom), AW'($urandom_range(0, 15)), $urandom);
                end
            end
            applyStimulus();
        end
        idleCycles(3);

        $display("[TB] reset with a read in flight");
        setRequest(0, 1'b0, 8'h05, '0);
        applyStimulus();
        pend_valid = '0;
        applyStimulus();
        checkOutput("flight_mem_en", 64'(bus.mem_en), 64'(1));
        asyncReset(2);
        idleCycles(4);
        setRequest(0, 1'b0, 8'h06, '0);
        setRequest(1, 1'b0, 8'h07, '0);
        applyStimulus();
        checkOutput("ptr_after_reset", 64'(obs_ready), 64'(2'b01));
        applyStimulus();
        idleCycles(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Multi-channel front end for a synchronous single-port RAM. It accepts read/write requests from NUM_PORTS independent requesters over a valid/ready handshake and arbitrates them round-robin onto one registered memory command port. It tracks in-flight reads through a latency pipeline so each read's data returns to the port that issued it. It sits between the CPU and DMA/SPI-side masters and the shared data memory, replacing the single-master CPU-to-memory connection.

## Interface
- ADDR_WIDTH, 8, memory word-address width
- DATA_WIDTH, 32, data word width
- NUM_PORTS, 2, number of requester channels (1..8)
- RD_LATENCY, 1, RAM cycles from mem_en to valid mem_rdata (1..3)

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_PORTS  per-port request valid
- req_ready  out  NUM_PORTS  per-port grant; at most one bit set
- req_we  in  NUM_PORTS  per-port 1=write, 0=read
- req_addr  in  NUM_PORTS*ADDR_WIDTH  packed addresses, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_PORTS*DATA_WIDTH  packed write data, same packing rule
- rsp_valid  out  NUM_PORTS  one-cycle read-data strobe for port p
- rsp_rdata  out  DATA_WIDTH  read data, shared by all ports, qualified by rsp_valid
- mem_en, mem_we  out  1  registered RAM command
- mem_addr  out  ADDR_WIDTH  registered RAM address
- mem_wdata  out  DATA_WIDTH  registered RAM write data
- mem_rdata  in  DATA_WIDTH  RAM read data

## Operation
- Handshake: a transfer occurs on a port in any cycle where req_valid[p] and req_ready[p] are both high. req_ready is combinational from req_valid and the priority pointer. A requester must not make req_valid depend on req_ready. A requester holds valid, we, addr and wdata stable until the transfer.
- Arbitration: among valid ports, the grant goes to the first one found searching upward from the pointer, with wrap-around. After a grant to port g, the pointer becomes (g+1) mod NUM_PORTS. With no valid requests, nothing is granted and the pointer is unchanged. One grant is issued per cycle, so throughput is one request per cycle.
- Command stage: a granted request is registered into mem_en=1 and its mem_we/addr/wdata. Without a grant, mem_en=0 and mem_we=0, while addr and wdata hold their last values.
- Read tracking: an RD_LATENCY-deep shift pipeline carries (valid, port id) for each issued read. Writes produce no response. At the pipeline tail, rsp_valid[id] pulses and rsp_rdata = mem_rdata.
- There is no response backpressure; requesters must always accept rsp_valid.
- Ordering: the RAM sees requests in grant order. A read issued after a write to the same address returns the written data.
- NUM_PORTS=1 degenerates to a pipeline register with ready = valid.

## Timing
- Reset values: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rsp_valid=0, pointer=0 (port 0 first), read pipeline empty.
- Request accepted in cycle T → mem_en high in T+1 → rsp_valid high in T+1+RD_LATENCY. The default total is 2 cycles.
- Back-to-back grants, including repeated grants to the same port when it is the only one valid, give mem_en high on consecutive cycles.
- Reset asserted mid-operation clears all in-flight reads immediately; no rsp_valid is produced for them after reset release.
- Between rsp_valid pulses, rsp_rdata is don't-care.

## Structure
- Package mem_arb_pkg holds:
  - the function for port-id width, $clog2 of NUM_PORTS with a minimum of 1
  - typedef mem_cmd_t {we, addr, wdata}, parametrised via localparams
  - typedef rd_tag_t {valid, id}
- Sub-module rr_arbiter (parameter N) handles arbitration: inputs clk, rst_n, req[N], advance; output one-hot grant[N]. It owns the pointer register.
- The top level owns the command register, the read-tag pipeline and the port packing/unpacking.

## Test plan
- Reset: hold rst_n low with random inputs → all mem_* outputs 0, rsp_valid=0, req_ready=0 while req_valid=0.
- Single read: with mem pre-loaded [0x10]=0xDEADBEEF, port 1 reads 0x10 at T → mem_en/addr=0x10 at T+1, rsp_valid=2'b10 with rsp_rdata=0xDEADBEEF at T+2; port 0 gets no strobe.
- Contention: ports 0 and 1 both hold valid reads for 4 cycles from reset → grants 0,1,0,1; responses alternate in the same order with the correct data.
- Write-then-read: port 0 writes 0x55AA55AA to 0x03, next cycle reads 0x03 → rsp_rdata=0x55AA55AA. There is no rsp_valid for the write.
- Streaming: port 0 alone issues 8 consecutive reads → req_ready high all 8 cycles, mem_en high 8 consecutive cycles, 8 responses in order.
- Reset mid-flight: issue a read, assert rst_n low the cycle mem_en is high → no rsp_valid after release, pointer back to 0.
